sprite_rom_arbiter: RTL and testbench

Shares one single-port, registered-read sprite ROM (palette-index output, fixed read latency) between several drawing requesters: player, enemies, projectiles and the death-animation overlay. Requesters present addresses with a valid/ready handshake. The arbiter picks a winner round-robin, lets it keep the port for a short burst (one sprite row segment), and returns each ROM word with a per-requester response strobe aligned to the ROM latency. It sits between the sprite engines and the ROM instance in the frame-drawing datapath.

---
 rtl/sprite_arb_pkg.sv | 23 ++
 rtl/sprite_rom_arbiter_rr_picker.sv | 34 +++
 rtl/sprite_rom_arbiter.sv | 148 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// sprite_arb_pkg: shared types and default widths for the sprite ROM arbiter.
package sprite_arb_pkg;

   localparam int SPR_ADDR_W = 19;
   localparam int SPR_DATA_W = 4;
   localparam int MAX_REQ    = 8;   // requester indices are carried in 3 bits

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_OWN  = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       vld;
      logic [2:0] idx;
   } tag_t;

   // Next requester index, wrapping n-1 back to 0.
   function automatic logic [2:0] idx_inc(input logic [2:0] i, input int n);
      return (int'(i) == n - 1) ? 3'd0 : i + 3'd1;
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority search. Returns the first set
// request at or after 'start', wrapping past N_REQ-1 to 0.
module rr_picker
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ = 4
)(
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       start,
   output logic             found,
   output logic [2:0]       idx
);

   logic [MAX_REQ-1:0] req_w;
   logic [3:0]         pos;

   // Scan from the farthest rotated slot down to start so the nearest hit is written last.
   always_comb begin
      req_w            = '0;
      req_w[N_REQ-1:0] = req;
      found            = 1'b0;
      idx              = '0;
      pos              = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = 4'(start) + 4'(k);
         if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
         if (req_w[pos[2:0]]) begin
            found = 1'b1;
            idx   = pos[2:0];
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin burst arbiter sharing one registered-read
// sprite ROM between drawing requesters, with latency-aligned response strobes.
// Optional: SPRITE_ARB_PRIO0_EN makes requester 0 (overlay) preempt other owners.
module sprite_rom_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = SPR_ADDR_W,
   parameter int DATA_W    = SPR_DATA_W,
   parameter int ROM_LAT   = 1,
   parameter int BURST_LEN = 8
)(
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]             req_ready,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [DATA_W-1:0]            rom_data,
   output logic [N_REQ-1:0]             rsp_valid,
   output logic [DATA_W-1:0]            rsp_data,
   output logic                         busy
);

   arb_state_e        state_q, state_d;
   logic [2:0]        owner_q, owner_d;
   logic [2:0]        rr_q, rr_d;
   logic [4:0]        beats_q, beats_d;
   logic [ADDR_W-1:0] rom_addr_q;
   tag_t              tag_q [ROM_LAT];

   logic              pick_found, win_found;
   logic [2:0]        pick_idx, win_idx;
   logic              own_valid, grant, burst_end;
   logic [2:0]        gnt_idx;
   logic [ADDR_W-1:0] sel_addr;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req   (req_valid),
      .start (rr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Per-index selects: owner's valid and the granted requester's address.
   always_comb begin
      own_valid = 1'b0;
      sel_addr  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == 3'(i)) own_valid = req_valid[i];
         if (gnt_idx == 3'(i)) sel_addr  = req_addr[i];
      end
   end

   // Next-state, grant and round-robin pointer update.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      beats_d   = beats_q;
      rr_d      = rr_q;
      grant     = 1'b0;
      gnt_idx   = owner_q;
      burst_end = 1'b0;
      win_found = pick_found;
      win_idx   = pick_idx;
`ifdef SPRITE_ARB_PRIO0_EN
      if (req_valid[0]) begin
         win_found = 1'b1;
         win_idx   = 3'd0;
      end
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (win_found) begin
               grant     = 1'b1;
               gnt_idx   = win_idx;
               owner_d   = win_idx;
               beats_d   = 5'd1;
               state_d   = ARB_OWN;
               burst_end = (BURST_LEN == 1);
            end
         end
         ARB_OWN: begin
            if (!own_valid) begin
               burst_end = 1'b1;
            end else begin
               grant     = 1'b1;
               beats_d   = beats_q + 5'd1;
               burst_end = (beats_d >= 5'(BURST_LEN));
            end
         end
         default: ;
      endcase
      if (burst_end) begin
         state_d = ARB_IDLE;
         rr_d    = idx_inc(owner_d, N_REQ);
`ifdef SPRITE_ARB_PRIO0_EN
         // Overlay bursts are out of band: keep the pointer where a preempted owner parked it.
         if (owner_d == 3'd0) rr_d = rr_q;
`endif
      end
`ifdef SPRITE_ARB_PRIO0_EN
      else if (state_q == ARB_OWN && grant && owner_q != 3'd0 && req_valid[0]) begin
         // Current beat completes; hand the port to 0 and let the victim win right after.
         state_d = ARB_IDLE;
         rr_d    = owner_q;
      end
`endif
      // Nothing may be accepted while reset is held, even if requesters stay valid.
      if (!Reset_n) grant = 1'b0;
   end

   // Arbitration state, held ROM address and response tag pipeline.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= ARB_IDLE;
         owner_q    <= '0;
         rr_q       <= '0;
         beats_q    <= '0;
         rom_addr_q <= '0;
         for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         beats_q <= beats_d;
         if (grant) rom_addr_q <= sel_addr;
         tag_q[0] <= '{vld: grant, idx: gnt_idx};
         for (int i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // One-hot ready/response decode and busy reduction.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant && (gnt_idx == 3'(i));
         rsp_valid[i] = tag_q[ROM_LAT-1].vld && (tag_q[ROM_LAT-1].idx == 3'(i));
      end
      busy = (state_q == ARB_OWN);
      for (int i = 0; i < ROM_LAT; i++) busy = busy | tag_q[i].vld;
   end

   assign rom_addr = grant ? sel_addr : rom_addr_q;
   assign rsp_data = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed plus randomized checks of sprite_rom_arbiter
// against a queue-based reference model and a behavioural ROM.
module tb_sprite_rom_arbiter;

   localparam int N   = 4;
   localparam int AW  = 19;
   localparam int DW  = 4;
   localparam int LAT = 3;
   localparam int BL  = 4;

   logic                 Clk = 1'b0;
   logic                 Reset_n;
   logic [N-1:0]         req_valid;
   logic [N-1:0][AW-1:0] req_addr;
   logic [N-1:0]         req_ready;
   logic [AW-1:0]        rom_addr;
   logic [DW-1:0]        rom_data;
   logic [N-1:0]         rsp_valid;
   logic [DW-1:0]        rsp_data;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: owner -1 means nobody holds the port
   int            m_owner = -1;
   int            m_beats = 0;
   int            m_rr    = 0;
   logic [AW-1:0] m_addr  = '0;

   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] dat;
   } rsp_t;
   rsp_t rq[$];

   logic [N-1:0][AW-1:0] addr_drv;
   logic [N-1:0]         rv;
   logic [N-1:0]         rv_log [8];
   logic [N-1:0]         vr;
   int                   g;

   always #5 Clk = ~Clk;

   sprite_rom_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .BURST_LEN(BL)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {1'b0, a[18:16]} ^ 4'h5;
   endfunction

   // registered-read ROM with LAT cycles of latency
   logic [DW-1:0] rom_pipe [LAT];
   always @(posedge Clk) begin
      rom_pipe[0] <= rom_word(rom_addr);
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v);
`ifdef SPRITE_ARB_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_rr + k) % N;
         if (v[c[1:0]]) return c;
      end
      return -1;
   endfunction

   task automatic end_burst();
`ifdef SPRITE_ARB_PRIO0_EN
      if (m_owner != 0) m_rr = (m_owner + 1) % N;
`else
      m_rr = (m_owner + 1) % N;
`endif
      m_owner = -1;
   endtask

   // one clock: drive, compare against the model, then advance the model
   task automatic step(input logic [N-1:0] v, output int og, output logic [N-1:0] orv);
      int            eg, ti;
      logic [N-1:0]  erdy, erv;
      logic [DW-1:0] edat;
      logic [AW-1:0] eaddr;
      logic          ebusy;
      @(negedge Clk);
      req_valid = v;
      req_addr  = addr_drv;
      #1;
      eg = -1;
      if (m_owner < 0) eg = pick(v);
      else if (v[m_owner[1:0]]) eg = m_owner;
      erdy = '0;
      if (eg >= 0) erdy[eg[1:0]] = 1'b1;
      eaddr = (eg >= 0) ? addr_drv[eg[1:0]] : m_addr;
      ebusy = (m_owner >= 0) || (rq.size() > 0);
      erv   = '0;
      edat  = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         ti           = rq[0].idx;
         erv[ti[1:0]] = 1'b1;
         edat         = rq[0].dat;
         void'(rq.pop_front());
      end
      check("req_ready", 32'(req_ready), 32'(erdy));
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("rom_addr", 32'(rom_addr), 32'(eaddr));
      check("rsp_valid", 32'(rsp_valid), 32'(erv));
      check("busy", 32'(busy), 32'(ebusy));
      if (erv != '0) check("rsp_data", 32'(rsp_data), 32'(edat));
      og = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) og = i;
      orv = rsp_valid;
      if (eg >= 0) begin
         m_addr = addr_drv[eg[1:0]];
         rq.push_back('{cyc + LAT, eg, rom_word(addr_drv[eg[1:0]])});
      end
      if (m_owner < 0) begin
         if (eg >= 0) begin
            m_owner = eg;
            m_beats = 1;
            if (m_beats == BL) end_burst();
         end
      end else if (eg < 0) begin
         end_burst();
      end else begin
         m_beats++;
         if (m_beats == BL) end_burst();
`ifdef SPRITE_ARB_PRIO0_EN
         else if (m_owner != 0 && v[0]) begin
            m_rr    = m_owner;
            m_owner = -1;
         end
`endif
      end
      cyc++;
   endtask

   task automatic do_reset(input logic [N-1:0] v);
      @(negedge Clk);
      Reset_n   = 1'b0;
      req_valid = v;
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(negedge Clk);
      req_valid = '0;
      #1;
      Reset_n = 1'b1;
      m_owner = -1;
      m_beats = 0;
      m_rr    = 0;
      m_addr  = '0;
      rq.delete();
   endtask

   initial begin
      Reset_n   = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      addr_drv  = '0;
      vr        = '0;
      #1 Reset_n = 1'b0;

      // power-up reset values
      do_reset('0);

      // single requester 2 streams 0x10..0x13: ready every cycle, rsp 3 cycles later
      for (int k = 0; k < 4; k++) begin
         addr_drv[2] = 19'h10 + 19'(k);
         step(4'b0100, g, rv_log[k]);
         check("s1_grant", 32'(g), 32'd2);
      end
      for (int k = 4; k < 8; k++) step('0, g, rv_log[k]);
      for (int k = 0; k < 8; k++)
         check("s1_rsp_timing", 32'(rv_log[k]), (k >= 3 && k <= 6) ? 32'h4 : 32'h0);

      // all four valid from reset: bursts of BL in round-robin order
      do_reset('0);
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < N; i++) addr_drv[i] = 19'($urandom);
         step(4'b1111, g, rv);
`ifdef SPRITE_ARB_PRIO0_EN
         check("rr_order_prio", 32'(g), 32'd0);
`else
         check("rr_order", 32'(g), 32'((k / BL) % N));
`endif
      end
      repeat (LAT + 1) step('0, g, rv);

      // requester 1 drops after 3 beats with 3 waiting: one idle cycle, then 3
      do_reset('0);
      repeat (3) begin
         step(4'b1010, g, rv);
         check("drop_own", 32'(g), 32'd1);
      end
      step(4'b1000, g, rv);
      check("drop_idle", 32'(g), 32'hFFFF_FFFF);
      step(4'b1000, g, rv);
      check("drop_next", 32'(g), 32'd3);
      repeat (LAT + 1) step('0, g, rv);

      // single beat at 0x00AF0: response exactly LAT cycles later with ROM word
      do_reset('0);
      addr_drv[0] = 19'h00AF0;
      step(4'b0001, g, rv);
      check("lat_grant", 32'(g), 32'd0);
      repeat (LAT - 1) begin
         step('0, g, rv);
         check("lat_early", 32'(rv), 32'd0);
      end
      step('0, g, rv);
      check("lat_rsp", 32'(rv), 32'd1);
      check("lat_data", 32'(rsp_data), 32'(rom_word(19'h00AF0)));

      // reset mid-burst with a tag in flight: nothing comes back afterwards
      do_reset('0);
      addr_drv[1] = 19'h12345;
      step(4'b0010, g, rv);
      check("mid_grant", 32'(g), 32'd1);
      do_reset(4'b0010);
      repeat (LAT + 1) begin
         step('0, g, rv);
         check("mid_no_rsp", 32'(rv), 32'd0);
      end

`ifdef SPRITE_ARB_PRIO0_EN
      // requester 0 preempts owner 2 in its third beat; 2 resumes ahead of 3
      do_reset('0);
      repeat (2) begin
         step(4'b0100, g, rv);
         check("pre_own2", 32'(g), 32'd2);
      end
      step(4'b0101, g, rv);
      check("pre_beat3", 32'(g), 32'd2);
      repeat (2) begin
         step(4'b1101, g, rv);
         check("pre_gnt0", 32'(g), 32'd0);
      end
      step(4'b1100, g, rv);
      check("pre_idle", 32'(g), 32'hFFFF_FFFF);
      step(4'b1100, g, rv);
      check("pre_resume2", 32'(g), 32'd2);
      repeat (LAT + 1) step('0, g, rv);
`endif

      // randomized traffic against the model, with one reset in the middle
      do_reset('0);
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) vr[i] = ~vr[i];
            addr_drv[i] = 19'($urandom);
         end
         if (k == 300) begin
            do_reset(vr);
         end
         step(vr, g, rv);
      end
      repeat (LAT + 2) step('0, g, rv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
